// File: rtl/phv_queue_arbiter_pkg.sv
// phv_queue_arbiter_pkg: shared PHV geometry and queue-id type for the queue arbiter.
package phv_queue_arbiter_pkg;
    localparam int PHV_LEN      = 48*8 + 32*8 + 16*8 + 256;
    localparam int C_NUM_QUEUES = 4;
    localparam int QMAP_LSB     = 141;
    localparam int QMAP_W       = 4;
    typedef logic [1:0] qid_t;

    function automatic logic [QMAP_W-1:0] phv_qmap(input logic [PHV_LEN-1:0] phv);
        return phv[QMAP_LSB +: QMAP_W];
    endfunction
endpackage

// File: rtl/phv_fifo.sv
// phv_fifo: single-clock FIFO with next-count, empty flag, overflow pulse and a combinational head.
module phv_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          axis_clk,
    input  logic          aresetn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  head_o,
    output logic [AW:0]   count_d_o,
    output logic          empty_o,
    output logic          ovf_o
);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wp_q, rp_q;
    logic [AW:0]   cnt_q;
    logic          wr, rd;
    assign empty_o   = cnt_q == '0;
    assign rd        = pop_i && !empty_o;
    // a pop in the same cycle frees the slot, so a push to a full FIFO still lands
    assign wr        = push_i && (cnt_q != FULL || rd);
    assign ovf_o     = push_i && !wr;
    assign head_o    = mem_q[rp_q];
    assign count_d_o = cnt_q + (AW+1)'(wr) - (AW+1)'(rd);
    always_ff @(posedge axis_clk) begin
        if (wr) mem_q[wp_q] <= data_i;
    end
    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            wp_q  <= '0;
            rp_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr) wp_q <= wp_q + 1'b1;
            if (rd) rp_q <= rp_q + 1'b1;
            cnt_q <= count_d_o;
        end
    end
endmodule

// File: rtl/phv_queue_arbiter.sv
// phv_queue_arbiter: four per-queue PHV FIFOs merged round-robin into one deparser stream.
// Per-queue dequeue counters are built only when PHV_ARB_STATS_EN is defined.
module phv_queue_arbiter
    import phv_queue_arbiter_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int AF_MARGIN  = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                              axis_clk,
    input  logic                              aresetn,
    input  logic [PHV_LEN-1:0]                phv_in_0,
    input  logic [PHV_LEN-1:0]                phv_in_1,
    input  logic [PHV_LEN-1:0]                phv_in_2,
    input  logic [PHV_LEN-1:0]                phv_in_3,
    input  logic                              phv_in_valid_0,
    input  logic                              phv_in_valid_1,
    input  logic                              phv_in_valid_2,
    input  logic                              phv_in_valid_3,
    output logic                              phv_fifo_ready_0,
    output logic                              phv_fifo_ready_1,
    output logic                              phv_fifo_ready_2,
    output logic                              phv_fifo_ready_3,
    output logic [PHV_LEN-1:0]                phv_out,
    output logic [1:0]                        phv_out_qid,
    output logic                              phv_out_valid,
    input  logic                              phv_out_ready,
    output logic [C_NUM_QUEUES-1:0]           ovf_err,
    output logic [C_NUM_QUEUES*CNT_WIDTH-1:0] stat_pkt_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic [PHV_LEN-1:0]      din  [C_NUM_QUEUES];
    logic [PHV_LEN-1:0]      head [C_NUM_QUEUES];
    logic [CW-1:0]           cnt_d [C_NUM_QUEUES];
    logic [C_NUM_QUEUES-1:0] push, pop, empty, ovf, rdy_d, rdy_q, ovf_q;
    logic [PHV_LEN-1:0]      out_q;
    qid_t                    qid_q, rr_q, gnt_idx;
    logic                    vld_q, gnt_vld, load;
    assign din[0] = phv_in_0;
    assign din[1] = phv_in_1;
    assign din[2] = phv_in_2;
    assign din[3] = phv_in_3;
    assign push   = {phv_in_valid_3, phv_in_valid_2, phv_in_valid_1, phv_in_valid_0};
    assign {phv_fifo_ready_3, phv_fifo_ready_2, phv_fifo_ready_1, phv_fifo_ready_0} = rdy_q;
    assign phv_out       = out_q;
    assign phv_out_qid   = qid_q;
    assign phv_out_valid = vld_q;
    assign ovf_err       = ovf_q;
    assign load          = !vld_q || phv_out_ready;

    for (genvar g = 0; g < C_NUM_QUEUES; g++) begin : g_q
        phv_fifo #(.W(PHV_LEN), .DEPTH(FIFO_DEPTH)) u_fifo (
            .axis_clk  (axis_clk),
            .aresetn   (aresetn),
            .push_i    (push[g]),
            .pop_i     (pop[g]),
            .data_i    (din[g]),
            .head_o    (head[g]),
            .count_d_o (cnt_d[g]),
            .empty_o   (empty[g]),
            .ovf_o     (ovf[g])
        );
        assign pop[g]   = load && gnt_vld && gnt_idx == qid_t'(g);
        assign rdy_d[g] = cnt_d[g] <= CW'(FIFO_DEPTH - AF_MARGIN);
    end

    // scan from farthest to nearest so the queue right after rr_q wins
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_q;
        for (int i = C_NUM_QUEUES; i >= 1; i--) begin
            if (!empty[rr_q + qid_t'(i)]) begin
                gnt_vld = 1'b1;
                gnt_idx = rr_q + qid_t'(i);
            end
        end
    end

    always_ff @(posedge axis_clk) begin
        if (!aresetn) begin
            rr_q  <= 2'd3;
            out_q <= '0;
            qid_q <= '0;
            vld_q <= 1'b0;
            ovf_q <= '0;
            rdy_q <= '1;
        end else begin
            ovf_q <= ovf_q | ovf;
            rdy_q <= rdy_d;
            if (load) begin
                vld_q <= gnt_vld;
                if (gnt_vld) begin
                    out_q <= head[gnt_idx];
                    qid_q <= gnt_idx;
                    rr_q  <= gnt_idx;
                end
            end
        end
    end

`ifdef PHV_ARB_STATS_EN
    for (genvar g = 0; g < C_NUM_QUEUES; g++) begin : g_st
        logic [CNT_WIDTH-1:0] cnt_q;
        always_ff @(posedge axis_clk) begin
            if (!aresetn) cnt_q <= '0;
            else if (vld_q && phv_out_ready && qid_q == qid_t'(g)) cnt_q <= cnt_q + 1'b1;
        end
        assign stat_pkt_cnt[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q;
    end
`else
    assign stat_pkt_cnt = '0;
`endif
endmodule

// File: tb/tb_phv_queue_arbiter.sv
// tb_phv_queue_arbiter: directed and randomized checks of the PHV queue arbiter against a queue-based model.
module tb_phv_queue_arbiter;
    import phv_queue_arbiter_pkg::*;
    localparam int DEPTH = 16;
    localparam int AF    = 4;
    localparam int CNTW  = 32;

    logic axis_clk = 1'b0;
    logic aresetn  = 1'b0;
    logic [PHV_LEN-1:0] phv_in [4];
    logic [3:0] vin;
    wire  [3:0] rdy;
    logic [PHV_LEN-1:0] phv_out;
    logic [1:0] phv_out_qid;
    logic phv_out_valid, phv_out_ready;
    logic [3:0] ovf_err;
    logic [4*CNTW-1:0] stat_pkt_cnt;
    int n_chk = 0;
    int n_fail = 0;

    logic [PHV_LEN-1:0] mq [4][$];
    logic [PHV_LEN-1:0] m_out;
    int m_qid, m_rr;
    bit m_vld;
    logic [3:0] m_ovf;
    logic [CNTW-1:0] m_cnt [4];

    always #5 axis_clk = ~axis_clk;

    phv_queue_arbiter #(.FIFO_DEPTH(DEPTH), .AF_MARGIN(AF), .CNT_WIDTH(CNTW)) dut (
        .axis_clk         (axis_clk),
        .aresetn          (aresetn),
        .phv_in_0         (phv_in[0]),
        .phv_in_1         (phv_in[1]),
        .phv_in_2         (phv_in[2]),
        .phv_in_3         (phv_in[3]),
        .phv_in_valid_0   (vin[0]),
        .phv_in_valid_1   (vin[1]),
        .phv_in_valid_2   (vin[2]),
        .phv_in_valid_3   (vin[3]),
        .phv_fifo_ready_0 (rdy[0]),
        .phv_fifo_ready_1 (rdy[1]),
        .phv_fifo_ready_2 (rdy[2]),
        .phv_fifo_ready_3 (rdy[3]),
        .phv_out          (phv_out),
        .phv_out_qid      (phv_out_qid),
        .phv_out_valid    (phv_out_valid),
        .phv_out_ready    (phv_out_ready),
        .ovf_err          (ovf_err),
        .stat_pkt_cnt     (stat_pkt_cnt)
    );

    task automatic chk(input string nm, input logic [PHV_LEN-1:0] got, input logic [PHV_LEN-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (low 192 bits)", nm, got[191:0], exp[191:0]);
        end
    endtask

    function automatic logic [PHV_LEN-1:0] mk(input logic [15:0] t);
        logic [PHV_LEN-1:0] v;
        for (int i = 0; i < PHV_LEN/32; i++) v[i*32 +: 32] = $urandom;
        v[15:0] = t;
        return v;
    endfunction

    // reference model: per-queue queues plus one output slot, advanced on every rising edge
    initial forever begin
        logic [3:0] er;
        logic [4*CNTW-1:0] es;
        int g;
        @(posedge axis_clk);
        if (!aresetn) begin
            for (int k = 0; k < 4; k++) begin
                mq[k].delete();
                m_cnt[k] = '0;
            end
            m_out = '0; m_qid = 0; m_rr = 3; m_vld = 0; m_ovf = '0;
        end else begin
            if (m_vld && phv_out_ready) m_cnt[m_qid] = m_cnt[m_qid] + 1;
            if (!m_vld || phv_out_ready) begin
                g = -1;
                for (int i = 1; i <= 4; i++)
                    if (g < 0 && mq[(m_rr + i) % 4].size() > 0) g = (m_rr + i) % 4;
                if (g >= 0) begin
                    m_out = mq[g].pop_front();
                    m_qid = g; m_rr = g; m_vld = 1;
                end else m_vld = 0;
            end
            for (int k = 0; k < 4; k++)
                if (vin[k]) begin
                    if (mq[k].size() < DEPTH) mq[k].push_back(phv_in[k]);
                    else m_ovf[k] = 1'b1;
                end
        end
        #1;
        for (int k = 0; k < 4; k++) er[k] = mq[k].size() <= DEPTH - AF;
`ifdef PHV_ARB_STATS_EN
        es = {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
`else
        es = '0;
`endif
        chk("valid", PHV_LEN'(phv_out_valid), PHV_LEN'(m_vld));
        chk("qid", PHV_LEN'(phv_out_qid), PHV_LEN'(m_qid));
        chk("data", phv_out, m_out);
        chk("ready", PHV_LEN'(rdy), PHV_LEN'(er));
        chk("ovf", PHV_LEN'(ovf_err), PHV_LEN'(m_ovf));
        chk("stat", PHV_LEN'(stat_pkt_cnt), PHV_LEN'(es));
    end

    task automatic pulse_reset();
        aresetn = 1'b0;
        vin = '0;
        @(negedge axis_clk);
        aresetn = 1'b1;
    endtask

    initial begin
        logic [PHV_LEN-1:0] a5;
        int pct;
        a5 = {128{8'hA5}};
        vin = '0;
        phv_out_ready = 1'b1;
        for (int k = 0; k < 4; k++) phv_in[k] = '0;
        repeat (2) @(negedge axis_clk);
        aresetn = 1'b1;
        @(negedge axis_clk);
        chk("rst_ready", PHV_LEN'(rdy), PHV_LEN'(4'hF));
        chk("rst_valid", PHV_LEN'(phv_out_valid), '0);
        chk("rst_rr_model", PHV_LEN'(m_rr), PHV_LEN'(3));

        // single push on queue 2
        phv_in[2] = a5; vin = 4'b0100;
        @(negedge axis_clk);
        vin = '0;
        @(negedge axis_clk);
        chk("t2_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
        chk("t2_qid", PHV_LEN'(phv_out_qid), PHV_LEN'(2));
        chk("t2_data", phv_out, a5);
        @(negedge axis_clk);
        chk("t2_drained", PHV_LEN'(phv_out_valid), '0);
`ifdef PHV_ARB_STATS_EN
        chk("t2_stat", PHV_LEN'(stat_pkt_cnt[2*CNTW +: CNTW]), PHV_LEN'(1));
`else
        chk("t2_stat", PHV_LEN'(stat_pkt_cnt), '0);
`endif

        // all queues push for 8 cycles: strict 0,1,2,3 rotation
        pulse_reset();
        for (int j = 0; j < 34; j++) begin
            vin = (j < 8) ? 4'hF : 4'h0;
            for (int k = 0; k < 4; k++) phv_in[k] = mk(16'(j*4 + k));
            @(negedge axis_clk);
            if (j >= 1 && j <= 32) begin
                chk("rr_valid", PHV_LEN'(phv_out_valid), PHV_LEN'(1));
                chk("rr_qid", PHV_LEN'(phv_out_qid), PHV_LEN'((j - 1) % 4));
            end
        end
        chk("rr_no_ovf", PHV_LEN'(ovf_err), '0);

        // fill queue 1 with the output stalled, then overflow it
        pulse_reset();
        phv_out_ready = 1'b0;
        for (int j = 0; j < 18; j++) begin
            vin = 4'b0010;
            phv_in[1] = mk(16'(j));
            @(negedge axis_clk);
            chk("af_ready", PHV_LEN'(rdy), PHV_LEN'((j <= 12) ? 4'hF : 4'hD));
            if (j >= 1) begin
                chk("bp_qid", PHV_LEN'(phv_out_qid), PHV_LEN'(1));
                chk("bp_tag", PHV_LEN'(phv_out[15:0]), '0);
            end
        end
        vin = '0;
        chk("af_ovf", PHV_LEN'(ovf_err), PHV_LEN'(4'b0010));
        chk("af_model_depth", PHV_LEN'(mq[1].size()), PHV_LEN'(16));
        phv_out_ready = 1'b1;
        for (int d = 0; d < 16; d++) begin
            @(negedge axis_clk);
            chk("drain_tag", PHV_LEN'(phv_out[15:0]), PHV_LEN'(d + 1));
        end
        @(negedge axis_clk);
        chk("drain_empty", PHV_LEN'(phv_out_valid), '0);

        // reset with every FIFO partly filled
        pulse_reset();
        phv_out_ready = 1'b0;
        for (int j = 0; j < 8; j++) begin
            vin = 4'hF;
            for (int k = 0; k < 4; k++) phv_in[k] = mk(16'(100 + j));
            @(negedge axis_clk);
        end
        vin = '0;
        aresetn = 1'b0;
        @(negedge axis_clk);
        chk("mr_valid", PHV_LEN'(phv_out_valid), '0);
        chk("mr_data", phv_out, '0);
        chk("mr_qid", PHV_LEN'(phv_out_qid), '0);
        chk("mr_ready", PHV_LEN'(rdy), PHV_LEN'(4'hF));
        chk("mr_ovf", PHV_LEN'(ovf_err), '0);
        chk("mr_stat", PHV_LEN'(stat_pkt_cnt), '0);
        aresetn = 1'b1;
        phv_out_ready = 1'b1;
        repeat (5) begin
            @(negedge axis_clk);
            chk("mr_no_stale", PHV_LEN'(phv_out_valid), '0);
        end

        // randomized traffic at several push rates, with rare resets
        for (int j = 0; j < 1800; j++) begin
            pct = 15 + 25 * ((j / 300) % 3);
            for (int k = 0; k < 4; k++) begin
                vin[k] = $urandom_range(0, 99) < pct;
                phv_in[k] = mk(16'($urandom));
            end
            phv_out_ready = $urandom_range(0, 9) < 7;
            aresetn = $urandom_range(0, 599) != 0;
            @(negedge axis_clk);
        end
        aresetn = 1'b1;
        vin = '0;
        phv_out_ready = 1'b1;
        repeat (70) @(negedge axis_clk);
        chk("final_idle", PHV_LEN'(phv_out_valid), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
